// File: rtl/xadc_sample_ctrl.sv
// XADC event-driven single-channel sequencer: CONVST on a fixed tick, DRP read on EOC,
// 12-bit sample presented on a valid/ready stream with sticky overrun/timeout/drop flags.
module xadc_sample_ctrl #(
  parameter int CLK_DIV = 3125,
  parameter int TIMEOUT = 255
) (
  input  logic        dclk_in,
  input  logic        resetn_in,
  input  logic        enable_in,
  input  logic        busy_in,
  input  logic        eoc_in,
  input  logic [4:0]  channel_in,
  input  logic        drdy_in,
  input  logic [15:0] do_in,
  output logic        convst_out,
  output logic        den_out,
  output logic        dwe_out,
  output logic [6:0]  daddr_out,
  output logic [15:0] di_out,
  output logic [11:0] sample_out,
  output logic        sample_valid_out,
  input  logic        sample_ready_in,
  output logic        overrun_out,
  output logic        timeout_out,
  output logic        drop_out,
  input  logic        clear_err_in
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CONV      = 3'd1,
    S_WAIT_EOC  = 3'd2,
    S_READ      = 3'd3,
    S_WAIT_DRDY = 3'd4
  } state_t;

  localparam logic [15:0] TICK_LAST = 16'(CLK_DIV - 1);
  localparam logic [9:0]  TO_LAST   = 10'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_tick_cnt;
  logic [9:0]  r_to_cnt;
  logic        r_convst;
  logic        r_den;
  logic [6:0]  r_daddr;
  logic [11:0] r_sample;
  logic        r_valid;
  logic        r_overrun;
  logic        r_timeout;
  logic        r_drop;

  logic w_tick;
  logic w_ovr_set;
  logic w_to_set;
  logic w_latch_addr;
  logic w_capture;
  logic w_handshake;
  logic w_load;
  logic w_drop_set;

  assign w_tick      = enable_in & (r_tick_cnt == TICK_LAST);
  assign w_handshake = r_valid & sample_ready_in;
  // A capture into a full, non-draining output slot keeps the old sample.
  assign w_load      = w_capture & (~r_valid | w_handshake);
  assign w_drop_set  = w_capture & r_valid & ~w_handshake;

  // Sample-rate tick counter, held at zero while sampling is disabled.
  always_ff @(posedge dclk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      r_tick_cnt <= 16'd0;
    end else if (!enable_in || (r_tick_cnt == TICK_LAST)) begin
      r_tick_cnt <= 16'd0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 16'd1;
    end
  end

  // Next-state and event decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_to_set     = 1'b0;
    w_latch_addr = 1'b0;
    w_capture    = 1'b0;
    w_ovr_set    = w_tick & (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_tick && busy_in) begin
          w_ovr_set = 1'b1;
        end else if (w_tick) begin
          w_state_nxt = S_CONV;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CONV: w_state_nxt = S_WAIT_EOC;
      S_WAIT_EOC: begin
        if (eoc_in) begin
          w_latch_addr = 1'b1;
          w_state_nxt  = S_READ;
        end else if (r_to_cnt == TO_LAST) begin
          w_to_set    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_EOC;
        end
      end
      S_READ: w_state_nxt = S_WAIT_DRDY;
      S_WAIT_DRDY: begin
        if (drdy_in) begin
          w_capture   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_to_cnt == TO_LAST) begin
          w_to_set    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_DRDY;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register plus the shared wait-state timeout counter (cleared on every state change).
  always_ff @(posedge dclk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      r_state  <= S_IDLE;
      r_to_cnt <= 10'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_to_cnt <= 10'd0;
      end else if ((r_state == S_WAIT_EOC) || (r_state == S_WAIT_DRDY)) begin
        r_to_cnt <= r_to_cnt + 10'd1;
      end else begin
        r_to_cnt <= 10'd0;
      end
    end
  end

  // XADC strobes decoded from the next state so they line up with CONV/READ.
  always_ff @(posedge dclk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      r_convst <= 1'b0;
      r_den    <= 1'b0;
      r_daddr  <= 7'd0;
    end else begin
      r_convst <= (w_state_nxt == S_CONV);
      r_den    <= (w_state_nxt == S_READ);
      if (w_latch_addr) begin
        r_daddr <= {2'b00, channel_in};
      end
    end
  end

  // Output stream slot.
  always_ff @(posedge dclk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      r_sample <= 12'd0;
      r_valid  <= 1'b0;
    end else if (w_load) begin
      r_sample <= do_in[15:4];
      r_valid  <= 1'b1;
    end else if (w_handshake) begin
      r_valid  <= 1'b0;
    end
  end

  // Sticky error flags; a set event in the clearing cycle wins.
  always_ff @(posedge dclk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_overrun <= w_ovr_set  | (r_overrun & ~clear_err_in);
      r_timeout <= w_to_set   | (r_timeout & ~clear_err_in);
      r_drop    <= w_drop_set | (r_drop    & ~clear_err_in);
    end
  end

  assign convst_out       = r_convst;
  assign den_out          = r_den;
  assign dwe_out          = 1'b0;
  assign daddr_out        = r_daddr;
  assign di_out           = 16'h0000;
  assign sample_out       = r_sample;
  assign sample_valid_out = r_valid;
  assign overrun_out      = r_overrun;
  assign timeout_out      = r_timeout;
  assign drop_out         = r_drop;

endmodule

// File: tb/tb_xadc_sample_ctrl.sv
// Directed bench for xadc_sample_ctrl with a small XADC model and a sample scoreboard.
module tb_xadc_sample_ctrl;
  localparam int CLK_DIV  = 100;
  localparam int TIMEOUT  = 255;
  localparam int EOC_LAT  = 12;
  localparam int DRDY_LAT = 4;

  logic        dclk_in = 1'b0;
  logic        resetn_in, enable_in, busy_in, eoc_in, drdy_in;
  logic [4:0]  channel_in;
  logic [15:0] do_in;
  logic        convst_out, den_out, dwe_out;
  logic [6:0]  daddr_out;
  logic [15:0] di_out;
  logic [11:0] sample_out;
  logic        sample_valid_out, sample_ready_in;
  logic        overrun_out, timeout_out, drop_out, clear_err_in;

  xadc_sample_ctrl #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .dclk_in(dclk_in), .resetn_in(resetn_in), .enable_in(enable_in), .busy_in(busy_in),
    .eoc_in(eoc_in), .channel_in(channel_in), .drdy_in(drdy_in), .do_in(do_in),
    .convst_out(convst_out), .den_out(den_out), .dwe_out(dwe_out), .daddr_out(daddr_out),
    .di_out(di_out), .sample_out(sample_out), .sample_valid_out(sample_valid_out),
    .sample_ready_in(sample_ready_in), .overrun_out(overrun_out), .timeout_out(timeout_out),
    .drop_out(drop_out), .clear_err_in(clear_err_in)
  );

  always #5 dclk_in = ~dclk_in;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          nvalid = 0;
  logic [11:0] exp_q[$];
  logic [15:0] model_do = 16'hABC0;
  int          push_budget = -1;
  logic        eoc_en = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // XADC model: EOC a fixed latency after CONVST (when enabled).
  always begin
    @(posedge dclk_in);
    if (convst_out && eoc_en) begin
      repeat (EOC_LAT) @(posedge dclk_in);
      #1 eoc_in = 1'b1;
      @(posedge dclk_in);
      #1 eoc_in = 1'b0;
    end
  end

  // XADC model: DRDY/DO after DEN; the expected sample is queued here.
  always begin
    logic [15:0] drv;
    @(posedge dclk_in);
    if (den_out) begin
      drv = model_do;
      repeat (DRDY_LAT - 1) @(posedge dclk_in);
      #1;
      drdy_in = 1'b1;
      do_in   = drv;
      if (push_budget != 0) begin
        exp_q.push_back(drv[15:4]);
        if (push_budget > 0) push_budget--;
      end
      @(posedge dclk_in);
      #1 drdy_in = 1'b0;
    end
  end

  // Scoreboard: every accepted sample must match the oldest expected one.
  always @(negedge dclk_in) begin
    logic [11:0] exp_v;
    if (sample_valid_out && sample_ready_in) begin
      check("stream_q_empty", 64'(exp_q.size() == 0), 64'd0);
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        check("stream_sample", 64'(sample_out), 64'(exp_v));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge dclk_in);
    #2;
    cyc++;
    if (sample_valid_out) nvalid++;
  endtask

  task automatic wait_convst();
    int lim;
    lim = cyc + 4 * CLK_DIV;
    do step(); while (!convst_out && cyc < lim);
    check("convst_seen", 64'(convst_out), 64'd1);
  endtask

  task automatic wait_eoc();
    int lim;
    lim = cyc + 2 * CLK_DIV;
    do step(); while (!eoc_in && cyc < lim);
    check("eoc_seen", 64'(eoc_in), 64'd1);
  endtask

  task automatic wait_den();
    int lim;
    lim = cyc + 2 * CLK_DIV;
    do step(); while (!den_out && cyc < lim);
    check("den_seen", 64'(den_out), 64'd1);
  endtask

  function automatic logic [63:0] all_out();
    return 64'({convst_out, den_out, dwe_out, daddr_out, di_out, sample_out,
                sample_valid_out, overrun_out, timeout_out, drop_out});
  endfunction

  initial begin
    int c0;
    int n;
    resetn_in = 1'b0; enable_in = 1'b0; busy_in = 1'b0; eoc_in = 1'b0; drdy_in = 1'b0;
    do_in = 16'h0000; channel_in = 5'h10; sample_ready_in = 1'b1; clear_err_in = 1'b0;

    repeat (3) step();
    check("reset_outputs", all_out(), 64'd0);
    resetn_in = 1'b1;
    step();

    // Nominal sampling: tick spacing, strobe timing, address, flags.
    enable_in = 1'b1;
    c0 = cyc;
    wait_convst();
    check("first_convst_delay", 64'(cyc - c0), 64'(CLK_DIV));
    for (int k = 0; k < 3; k++) begin
      c0 = cyc;
      nvalid = 0;
      step();
      check("convst_width", 64'(convst_out), 64'd0);
      wait_eoc();
      step();
      check("den_after_eoc", 64'(den_out), 64'd1);
      check("daddr", 64'(daddr_out), 64'h10);
      check("dwe_di_zero", 64'({dwe_out, di_out}), 64'd0);
      step();
      check("den_width", 64'(den_out), 64'd0);
      wait_convst();
      check("convst_period", 64'(cyc - c0), 64'(CLK_DIV));
      check("valid_one_cycle", 64'(nvalid), 64'd1);
      check("flags_clean", 64'({overrun_out, timeout_out, drop_out}), 64'd0);
      check("q_drained", 64'(exp_q.size()), 64'd0);
    end

    // Back-pressure for three ticks: first sample held, later ones dropped.
    sample_ready_in = 1'b0;
    push_budget = 1;
    model_do = 16'h1110;
    repeat (60) step();
    check("bp_first_valid", 64'(sample_valid_out), 64'd1);
    check("bp_first_sample", 64'(sample_out), 64'h111);
    check("bp_no_drop_yet", 64'(drop_out), 64'd0);
    wait_convst();
    model_do = 16'h2220;
    repeat (60) step();
    check("bp_drop_set", 64'(drop_out), 64'd1);
    check("bp_held_2", 64'(sample_out), 64'h111);
    wait_convst();
    model_do = 16'h3330;
    repeat (60) step();
    check("bp_held_3", 64'({sample_valid_out, sample_out}), 64'h1111);
    sample_ready_in = 1'b1;
    push_budget = -1;
    model_do = 16'hABC0;
    step();
    check("bp_valid_drop", 64'(sample_valid_out), 64'd0);
    check("bp_q_drained", 64'(exp_q.size()), 64'd0);
    clear_err_in = 1'b1;
    step();
    clear_err_in = 1'b0;
    check("drop_cleared", 64'(drop_out), 64'd0);

    // Busy at a tick: no conversion, overrun flagged, then cleared.
    wait_convst();
    c0 = cyc;
    repeat (60) step();
    busy_in = 1'b1;
    n = 0;
    repeat (CLK_DIV) begin
      step();
      if (convst_out) n++;
    end
    check("busy_no_convst", 64'(n), 64'd0);
    check("busy_overrun", 64'(overrun_out), 64'd1);
    busy_in = 1'b0;
    clear_err_in = 1'b1;
    step();
    clear_err_in = 1'b0;
    check("overrun_cleared", 64'(overrun_out), 64'd0);
    wait_convst();
    check("busy_next_convst", 64'(cyc - c0), 64'(2 * CLK_DIV));

    // EOC never arrives: one edge into WAIT_EOC, then TIMEOUT cycles there.
    eoc_en = 1'b0;
    c0 = cyc;
    do step(); while (!timeout_out && cyc < c0 + 2 * TIMEOUT);
    check("timeout_set", 64'(timeout_out), 64'd1);
    check("timeout_delay", 64'(cyc - c0), 64'(TIMEOUT + 1));
    eoc_en = 1'b1;
    wait_convst();
    check("timeout_next_convst", 64'(cyc - c0), 64'(3 * CLK_DIV));
    check("timeout_overrun", 64'(overrun_out), 64'd1);

    // Reset while waiting for DRDY; the late DRDY must be ignored.
    model_do = 16'hFFF0;
    push_budget = 0;
    clear_err_in = 1'b1;
    step();
    clear_err_in = 1'b0;
    check("flags_cleared", 64'({overrun_out, timeout_out, drop_out}), 64'd0);
    wait_den();
    step();
    check("pre_reset_daddr", 64'(daddr_out), 64'h10);
    #1 resetn_in = 1'b0;
    #1 check("async_reset_outputs", all_out(), 64'd0);
    step();
    step();
    resetn_in = 1'b1;
    c0 = cyc;
    nvalid = 0;
    wait_convst();
    check("post_reset_convst", 64'(cyc - c0), 64'(CLK_DIV));
    check("late_drdy_ignored", 64'({nvalid[7:0], sample_out}), 64'd0);

    // Capture coinciding with a handshake.
    push_budget = -1;
    sample_ready_in = 1'b0;
    model_do = 16'h5550;
    repeat (60) step();
    check("co_first_held", 64'({sample_valid_out, sample_out}), 64'h1555);
    wait_convst();
    model_do = 16'h6660;
    c0 = cyc;
    do step(); while (!drdy_in && cyc < c0 + CLK_DIV);
    check("co_drdy_seen", 64'(drdy_in), 64'd1);
    sample_ready_in = 1'b1;
    step();
    check("co_second_loaded", 64'({sample_valid_out, sample_out}), 64'h1666);
    check("co_no_drop", 64'(drop_out), 64'd0);
    step();
    check("co_valid_drop", 64'(sample_valid_out), 64'd0);
    check("co_q_drained", 64'(exp_q.size()), 64'd0);

    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/xadc_sample_ctrl.md
Name: xadc_sample_ctrl

Overview:
- Sequences the XADC in event-driven single-channel mode for the MFCC audio front end.
- Issues CONVST at a fixed programmable sample rate and reads each result over the DRP when EOC fires.
- Presents the 12-bit sample (DO[15:4]) on a valid/ready stream to the MFCC feature pipeline.
- Flags missed sample ticks, stalled conversions and dropped samples.

Parameters:
- CLK_DIV, 3125: dclk cycles per sample tick (50 MHz / 16 kHz); legal range 64..65535.
- TIMEOUT, 255: max dclk cycles in a WAIT state before abort; legal range 32..1023.

Ports:
- dclk_in  in  1  system/DRP clock, rising edge.
- resetn_in  in  1  asynchronous active-low reset.
- enable_in  in  1  sampling enable.
- busy_in  in  1  XADC busy_out.
- eoc_in  in  1  XADC eoc_out.
- channel_in  in  5  XADC channel_out.
- drdy_in  in  1  XADC drdy_out.
- do_in  in  16  XADC do_out.
- convst_out  out  1  XADC convst_in.
- den_out  out  1  XADC den_in.
- dwe_out  out  1  XADC dwe_in, constant 0.
- daddr_out  out  7  XADC daddr_in.
- di_out  out  16  XADC di_in, constant 0.
- sample_out  out  12  captured sample.
- sample_valid_out  out  1  sample available.
- sample_ready_in  in  1  downstream accept.
- overrun_out  out  1  sticky: tick missed.
- timeout_out  out  1  sticky: WAIT state expired.
- drop_out  out  1  sticky: sample discarded.
- clear_err_in  in  1  clears all sticky flags.

Behaviour:
- Reset (async, resetn_in low) forces all outputs to 0 and all state to reset values:
  - FSM to IDLE; tick counter, timeout counter and sample register to 0.
  - Reset mid-transaction abandons the transaction. No DRP or CONVST activity is emitted until a new tick.
- Tick counter:
  - Counts 0..CLK_DIV-1 while enable_in=1. The tick is a 1-cycle pulse when count==CLK_DIV-1, then count wraps to 0.
  - enable_in=0 holds the count at 0, so the first tick arrives CLK_DIV cycles after enable rises.
- FSM states: IDLE, CONV, WAIT_EOC, READ, WAIT_DRDY.
  - IDLE: on tick with busy_in=0, go to CONV.
  - IDLE: on tick with busy_in=1, set overrun_out and stay in IDLE.
  - CONV: convst_out=1 for exactly one cycle, registered, so it asserts the cycle after the tick. Then go to WAIT_EOC.
  - WAIT_EOC: on eoc_in=1, latch daddr_out={2'b00,channel_in} and go to READ.
  - READ: den_out=1 for exactly one cycle, which is the cycle after EOC. daddr_out is stable. dwe_out=0. Then go to WAIT_DRDY.
  - WAIT_DRDY: on drdy_in=1, capture do_in[15:4] and go to IDLE.
- Timeouts:
  - WAIT_EOC and WAIT_DRDY share a counter that is cleared on state entry.
  - Reaching TIMEOUT sets timeout_out, returns the FSM to IDLE and captures no sample.
- Any tick while the FSM is not in IDLE sets overrun_out. The tick is discarded; no queuing.
- enable_in falling mid-transaction: the current transaction completes normally, then the FSM stays in IDLE.
- Output stream:
  - sample_valid_out rises the cycle after the drdy capture, with sample_out valid in the same cycle.
  - sample_out and sample_valid_out hold until sample_valid_out & sample_ready_in at a rising edge; valid then drops the next cycle.
  - If a capture occurs while valid=1 and there is no handshake in that cycle: the old sample is kept, the new one is discarded, and drop_out is set.
  - If a capture and a handshake occur in the same cycle: the new sample loads and valid stays 1, with no drop.
- Sticky flags:
  - clear_err_in=1 clears all three flags at the next edge.
  - If clear and a new set event occur in the same cycle, set wins.
- Throughput: one sample per tick, provided the XADC conversion plus DRP read completes within CLK_DIV cycles.

Test Plan:
- Functional XADC model, CLK_DIV=100. Release reset, enable=1, ready=1:
  - convst pulses 1 cycle at cycles 101, 201, 301…
  - den pulses 1 cycle after each eoc, with daddr=7'h10 for channel 5'h10.
  - With do=16'hABC0, sample_out=12'hABC, valid high 1 cycle per sample, no flags set.
- ready=0 for 3 ticks:
  - The first sample is held unchanged; drop_out=1 after the second capture.
  - Raising ready delivers the first sample, then valid drops.
- Model with busy held high at a tick: no convst, overrun_out=1. clear_err_in pulse -> overrun_out=0.
- Model never asserts eoc, TIMEOUT=255:
  - timeout_out=1 at 255 cycles after WAIT_EOC entry; FSM back in IDLE.
  - The next tick issues convst normally.
- Reset asserted while in WAIT_DRDY (after den):
  - All outputs 0 immediately, asynchronously.
  - A late drdy with do=16'hFFF0 yields no sample; next convst occurs 100 cycles after reset release.
- Capture coinciding with a handshake: sample 1 accepted, sample 2 loaded in the same edge, valid stays high, drop_out=0.
